rf_issue_ctrl: RTL and testbench
================================

Name: rf_issue_ctrl

Overview:
Single-issue operand-fetch and write-back sequencer that sits directly upstream of the 32x32 register file. It accepts R-type instructions over a valid/ready handshake and drives the register file's read and write ports. It delivers fetched operands to the ALU and writes the ALU result back.
- All register-file traffic is serialised, so a read and a write never share a cycle.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register index width.
- ZERO_REG_RO, 1, when 1 a write-back to register 0 is suppressed.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- instr_ready  out  1  stage can accept an instruction.
- rf_read1  out  ADDR_W  register-file read address 1.
- rf_read2  out  ADDR_W  register-file read address 2.
- rf_write_reg  out  ADDR_W  register-file write address.
- rf_write_data  out  DATA_W  register-file write data.
- rf_write_en  out  1  register-file write strobe.
- rf_data_1  in  DATA_W  register-file read data 1, valid one cycle after address.
- rf_data_2  in  DATA_W  register-file read data 2, valid one cycle after address.
- op_valid  out  1  operands valid to ALU.
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- op_funct  out  6  ALU function.
- op_ready  in  1  ALU accepts operands.
- res_valid  in  1  ALU result valid.
- res_data  in  DATA_W  ALU result.
- res_ready  out  1  stage accepts result.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; every output 0, including instr_ready, op_*, rf_*, res_ready.
- States:
  - IDLE: instr_ready=1. On instr_valid&instr_ready at an edge, latch rs, rt, rd and funct, then go to RD.
  - RD (1 cycle): rf_read1=rs, rf_read2=rt, rf_write_en=0. Go to CAP.
  - CAP (1 cycle): rf_data_1/rf_data_2 are valid. Register them into op_a/op_b, then go to ISSUE.
  - ISSUE: op_valid=1. op_a, op_b and op_funct are held stable until op_ready. On op_valid&op_ready, go to WAIT_RES; op_valid falls on the next cycle.
  - WAIT_RES: res_ready=1. On res_valid, latch res_data and go to WB.
  - WB (1 cycle): rf_write_reg=rd, rf_write_data=latched result, rf_write_en=1. Exception: when rd==0 and ZERO_REG_RO=1, rf_write_en stays 0. Go to IDLE.
- Handshake and latency:
  - instr_ready is registered and equals (state==IDLE); it is never combinationally dependent on instr_valid.
  - Minimum latency from acceptance edge to op_valid high is 3 cycles.
  - Minimum issue interval is 6 cycles; back-to-back acceptance is impossible by construction.
- Port discipline:
  - rf_write_en is asserted only in WB; reads are addressed only in RD.
  - rf_read*/rf_write_* hold their last value outside their states.
- Boundary conditions:
  - op_ready or res_valid asserted in the wrong state is ignored.
  - rs==rt is legal; both operands carry the same value.
  - rd equal to rs/rt needs no hazard logic because operation is fully serialised.
  - A later instruction reading the rd just written sees the new value: its RD cycle is at least one cycle after WB.
- Reset mid-operation: the in-flight instruction is discarded with no write-back. All outputs return to 0 immediately (asynchronously); instr_ready rises on the first edge after rst_n deasserts.

Optional Feature:
- Macro: RF_ISSUE_CNT_EN.
- Defined: adds output retire_cnt, 16 bits. It is reset to 0 and increments by 1 in every WB cycle, including suppressed rd==0 writes, wrapping 0xFFFF->0x0000.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 mid-ISSUE -> op_valid and rf_write_en drop to 0 without waiting for clk; after release, instr_ready=1, no write-back.
- Basic add: regfile r3=3, r4=4; instr rs=3, rt=4, rd=5, funct=0x20 -> rf_read1=3/rf_read2=4 in RD; op_a=3, op_b=4, op_funct=0x20 three cycles after accept; ALU returns 7 -> one WB cycle with rf_write_reg=5, rf_write_data=7, rf_write_en=1.
- Backpressure: op_ready low 5 cycles -> op_valid held high, op_a/op_b stable; res_valid pulsed during ISSUE ignored.
- Zero register: rd=0, result 0xDEADBEEF -> rf_write_en never asserts; retire_cnt still increments if enabled.
- Read-after-write: instr A writes r5=0x11; instr B rs=5 -> B's op_a=0x11.
- Counter wrap (RF_ISSUE_CNT_EN): preload retire_cnt=0xFFFF via force, retire one instr -> 0x0000.

Source files
------------

// File: rtl/rf_issue_ctrl.sv
// rf_issue_ctrl
// Single-issue operand-fetch / write-back sequencer placed directly in front
// of a 32x32 register file. One R-type instruction is in flight at a time:
//   IDLE -> RD -> CAP -> ISSUE -> WAIT_RES -> WB -> IDLE
// so register-file reads and writes never share a cycle and no hazard logic
// is needed.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   instr_valid/instr/instr_ready instruction handshake (rs=[25:21],
//                                 rt=[20:16], rd=[15:11], funct=[5:0])
//   rf_read1/rf_read2             register-file read addresses
//   rf_data_1/rf_data_2           read data, valid one cycle after address
//   rf_write_reg/_data/_en        register-file write port
//   op_valid/op_a/op_b/op_funct   operands to the ALU, op_ready from the ALU
//   res_valid/res_data/res_ready  result handshake from the ALU
//
// Optional feature: define RF_ISSUE_CNT_EN to add a 16-bit retire_cnt output
// that counts every WB cycle (including suppressed writes to register 0).
//
// Every output is a flop, so all outputs clear asynchronously on reset.

module rf_issue_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_read1,
  output logic [ADDR_W-1:0] rf_read2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic              op_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [5:0]        op_funct,
  input  logic              op_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready
`ifdef RF_ISSUE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    CAP      = 3'd2,
    ISSUE    = 3'd3,
    WAIT_RES = 3'd4,
    WB       = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [5:0]        funct_q, funct_d;

  logic              instr_ready_q, instr_ready_d;
  logic [ADDR_W-1:0] rf_read1_q, rf_read1_d;
  logic [ADDR_W-1:0] rf_read2_q, rf_read2_d;
  logic [ADDR_W-1:0] rf_write_reg_q, rf_write_reg_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
  logic              rf_write_en_q, rf_write_en_d;
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [5:0]        op_funct_q, op_funct_d;
  logic              res_ready_q, res_ready_d;

  // Opcode and shamt fields are not used by this stage.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:26], instr[10:6]};

  // Next-state and next-output logic. Address/data outputs default to
  // holding their last value; the strobes and readies are recomputed from
  // the next state so each registered output is aligned with its state.
  always_comb begin
    state_d         = state_q;
    rd_d            = rd_q;
    funct_d         = funct_q;
    rf_read1_d      = rf_read1_q;
    rf_read2_d      = rf_read2_q;
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    op_funct_d      = op_funct_q;

    case (state_q)
      IDLE: begin
        // instr_ready_q is low on the first cycle after reset, so nothing is
        // accepted until the registered ready has actually been presented.
        if (instr_valid && instr_ready_q) begin
          rf_read1_d = instr[21 +: ADDR_W];
          rf_read2_d = instr[16 +: ADDR_W];
          rd_d       = instr[11 +: ADDR_W];
          funct_d    = instr[5:0];
          state_d    = RD;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        op_a_d     = rf_data_1;
        op_b_d     = rf_data_2;
        op_funct_d = funct_q;
        state_d    = ISSUE;
      end
      ISSUE: begin
        if (op_ready) begin
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (res_valid) begin
          rf_write_reg_d  = rd_q;
          rf_write_data_d = res_data;
          state_d         = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    instr_ready_d = (state_d == IDLE);
    op_valid_d    = (state_d == ISSUE);
    res_ready_d   = (state_d == WAIT_RES);
    // Register 0 is hard-wired to zero in the file, so its write is dropped.
    rf_write_en_d = (state_d == WB) && !(ZERO_REG_RO && (rd_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rd_q            <= '0;
      funct_q         <= '0;
      instr_ready_q   <= 1'b0;
      rf_read1_q      <= '0;
      rf_read2_q      <= '0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
      rf_write_en_q   <= 1'b0;
      op_valid_q      <= 1'b0;
      op_a_q          <= '0;
      op_b_q          <= '0;
      op_funct_q      <= '0;
      res_ready_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_q            <= rd_d;
      funct_q         <= funct_d;
      instr_ready_q   <= instr_ready_d;
      rf_read1_q      <= rf_read1_d;
      rf_read2_q      <= rf_read2_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
      rf_write_en_q   <= rf_write_en_d;
      op_valid_q      <= op_valid_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      op_funct_q      <= op_funct_d;
      res_ready_q     <= res_ready_d;
    end
  end

  assign instr_ready   = instr_ready_q;
  assign rf_read1      = rf_read1_q;
  assign rf_read2      = rf_read2_q;
  assign rf_write_reg  = rf_write_reg_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_write_en   = rf_write_en_q;
  assign op_valid      = op_valid_q;
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign op_funct      = op_funct_q;
  assign res_ready     = res_ready_q;

`ifdef RF_ISSUE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;

  // Counts WB cycles, not actual writes; wraps naturally at 16 bits.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (state_q == WB) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= 16'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_rf_issue_ctrl.sv
// tb_rf_issue_ctrl
// Self-checking bench for rf_issue_ctrl. The bench plays the register file
// (one-cycle read latency) and the ALU. A reference model of the
// architectural registers (modelRegs) is updated from instruction semantics
// only: rd <= alu(rs, rt) unless rd is register 0. Inputs are driven and
// outputs sampled on the falling edge, away from the active edge.
// Define RF_ISSUE_CNT_EN to also check the retire counter.

module tb_rf_issue_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              instr_valid = 1'b0;
  logic [31:0]       instr = '0;
  logic              instr_ready;
  logic [ADDR_W-1:0] rf_read1, rf_read2, rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_en;
  logic [DATA_W-1:0] rf_data_1 = '0;
  logic [DATA_W-1:0] rf_data_2 = '0;
  logic              op_valid;
  logic [DATA_W-1:0] op_a, op_b;
  logic [5:0]        op_funct;
  logic              op_ready = 1'b0;
  logic              res_valid = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic              res_ready;
`ifdef RF_ISSUE_CNT_EN
  logic [15:0]       retire_cnt;
  logic [15:0]       expRetire = 16'd0;
`endif

  rf_issue_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .ZERO_REG_RO(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .rf_read1(rf_read1),
    .rf_read2(rf_read2),
    .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data),
    .rf_write_en(rf_write_en),
    .rf_data_1(rf_data_1),
    .rf_data_2(rf_data_2),
    .op_valid(op_valid),
    .op_a(op_a),
    .op_b(op_b),
    .op_funct(op_funct),
    .op_ready(op_ready),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_ready(res_ready)
`ifdef RF_ISSUE_CNT_EN
    ,
    .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Register file stand-in: writes when strobed, read data follows the
  // address seen one falling edge earlier (one-cycle read latency).
  logic [31:0] regs [32];
  logic [4:0]  lastAddr1 = '0;
  logic [4:0]  lastAddr2 = '0;
  logic        regsLoaded = 1'b0;

  always @(negedge clk) begin
    if (!regsLoaded) begin
      for (int i = 0; i < 32; i++) regs[i] = 32'(i);
      regsLoaded = 1'b1;
    end
    if (rf_write_en) regs[rf_write_reg] = rf_write_data;
    rf_data_1 = regs[lastAddr1];
    rf_data_2 = regs[lastAddr2];
    lastAddr1 = rf_read1;
    lastAddr2 = rf_read2;
  end

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    int          opDelay;
    int          resDelay;
    bit          pulseWrong;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] res;
  } vec_t;

  int          numCompared = 0;
  int          numMismatched = 0;
  logic [31:0] modelRegs [32];
  vec_t        vecs [7];
  logic [5:0]  functs [5];

  function automatic logic [31:0] aluRef(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a + b;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numCompared++;
    if (actual !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Offers one instruction and walks it through every stage, checking the
  // outputs of each cycle. The bench's ALU answers with v.res.
  task automatic applyStimulus(input vec_t v);
    int waitCnt;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {6'($urandom), v.rs, v.rt, v.rd, 5'($urandom), v.funct};
    waitCnt = 0;
    while (instr_ready !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (instr_ready !== 1'b1) begin
      checkOutput("accept_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    // RD
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    checkOutput("rd_read1", 32'(rf_read1), 32'(v.rs));
    checkOutput("rd_read2", 32'(rf_read2), 32'(v.rt));
    checkOutput("rd_wen", 32'(rf_write_en), 32'd0);
    checkOutput("rd_ready", 32'(instr_ready), 32'd0);
    // CAP
    @(negedge clk);
    checkOutput("cap_opvalid", 32'(op_valid), 32'd0);
    // ISSUE: third cycle after the acceptance edge
    @(negedge clk);
    checkOutput("iss_opvalid", 32'(op_valid), 32'd1);
    checkOutput("iss_op_a", op_a, v.expA);
    checkOutput("iss_op_b", op_b, v.expB);
    checkOutput("iss_funct", 32'(op_funct), 32'(v.funct));
    if (v.pulseWrong) begin
      res_valid = 1'b1;
      res_data = $urandom;
    end
    repeat (v.opDelay) begin
      @(negedge clk);
      checkOutput("hold_opvalid", 32'(op_valid), 32'd1);
      checkOutput("hold_op_a", op_a, v.expA);
      checkOutput("hold_op_b", op_b, v.expB);
      checkOutput("hold_resready", 32'(res_ready), 32'd0);
    end
    op_ready = 1'b1;
    // WAIT_RES
    @(negedge clk);
    op_ready = v.pulseWrong;
    res_valid = 1'b0;
    checkOutput("wait_opvalid", 32'(op_valid), 32'd0);
    checkOutput("wait_resready", 32'(res_ready), 32'd1);
    repeat (v.resDelay) begin
      @(negedge clk);
      checkOutput("wait_resready", 32'(res_ready), 32'd1);
      checkOutput("wait_wen", 32'(rf_write_en), 32'd0);
    end
    res_valid = 1'b1;
    res_data = v.res;
    // WB
    @(negedge clk);
    res_valid = 1'b0;
    res_data = $urandom;
    op_ready = 1'b0;
    checkOutput("wb_wen", 32'(rf_write_en), (v.rd != 5'd0) ? 32'd1 : 32'd0);
    checkOutput("wb_reg", 32'(rf_write_reg), 32'(v.rd));
    checkOutput("wb_data", rf_write_data, v.res);
    checkOutput("wb_resready", 32'(res_ready), 32'd0);
    checkOutput("wb_read1_held", 32'(rf_read1), 32'(v.rs));
    if (v.rd != 5'd0) modelRegs[v.rd] = v.res;
`ifdef RF_ISSUE_CNT_EN
    expRetire = expRetire + 16'd1;
`endif
    // back in IDLE
    @(negedge clk);
    checkOutput("idle_wen", 32'(rf_write_en), 32'd0);
    checkOutput("idle_ready", 32'(instr_ready), 32'd1);
`ifdef RF_ISSUE_CNT_EN
    checkOutput("retire_cnt", 32'(retire_cnt), 32'(expRetire));
`endif
  endtask

  initial begin
    int waitCnt;
    vec_t v;

    for (int i = 0; i < 32; i++) modelRegs[i] = 32'(i);
    functs[0] = 6'h20; functs[1] = 6'h22; functs[2] = 6'h24;
    functs[3] = 6'h25; functs[4] = 6'h26;

    // Directed vectors, expected values worked out from regs[i] = i.
    vecs[0] = '{5'd3, 5'd4,  5'd5,  6'h20, 0, 0, 1'b0, 32'd3,  32'd4,  32'd7};
    vecs[1] = '{5'd5, 5'd2,  5'd6,  6'h22, 5, 2, 1'b1, 32'd7,  32'd2,  32'd5};
    vecs[2] = '{5'd1, 5'd2,  5'd0,  6'h20, 1, 1, 1'b0, 32'd1,  32'd2,  32'hDEADBEEF};
    vecs[3] = '{5'd8, 5'd9,  5'd5,  6'h20, 0, 0, 1'b0, 32'd8,  32'd9,  32'h11};
    vecs[4] = '{5'd5, 5'd5,  5'd7,  6'h20, 0, 0, 1'b0, 32'h11, 32'h11, 32'h22};
    vecs[5] = '{5'd7, 5'd1,  5'd7,  6'h26, 2, 1, 1'b1, 32'h22, 32'd1,  32'h23};
    vecs[6] = '{5'd0, 5'd31, 5'd31, 6'h24, 0, 3, 1'b0, 32'd0,  32'd31, 32'd0};

    // Power-on reset: every output low while rst_n is low.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_ready", 32'(instr_ready), 32'd0);
    checkOutput("rst_opvalid", 32'(op_valid), 32'd0);
    checkOutput("rst_wen", 32'(rf_write_en), 32'd0);
    checkOutput("rst_resready", 32'(res_ready), 32'd0);
    checkOutput("rst_op_a", op_a, 32'd0);
    checkOutput("rst_wdata", rf_write_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rel_ready_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    checkOutput("rel_ready_high", 32'(instr_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of ISSUE: outputs fall without a clock edge and
    // the instruction (rd = 9) never writes back.
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {6'd0, 5'd6, 5'd7, 5'd9, 5'd0, 6'h20};
    waitCnt = 0;
    while (instr_ready !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("mid_accept", 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_opvalid", 32'(op_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_opvalid", 32'(op_valid), 32'd0);
    checkOutput("async_op_a", op_a, 32'd0);
    checkOutput("async_wen", 32'(rf_write_en), 32'd0);
    checkOutput("async_read1", 32'(rf_read1), 32'd0);
    checkOutput("async_ready", 32'(instr_ready), 32'd0);
`ifdef RF_ISSUE_CNT_EN
    expRetire = 16'd0;
    checkOutput("async_retire", 32'(retire_cnt), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("mid_rel_ready_low", 32'(instr_ready), 32'd0);
    @(negedge clk);
    checkOutput("mid_rel_ready_high", 32'(instr_ready), 32'd1);
    checkOutput("mid_rel_wen", 32'(rf_write_en), 32'd0);

`ifdef RF_ISSUE_CNT_EN
    // Counter wrap: preload all-ones, one retirement brings it to zero.
    force dut.retire_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.retire_cnt_q;
    expRetire = 16'hFFFF;
    @(negedge clk);
    checkOutput("retire_preload", 32'(retire_cnt), 32'hFFFF);
    v = '{5'd2, 5'd3, 5'd0, 6'h20, 0, 0, 1'b0, modelRegs[2], modelRegs[3], 32'h0BAD0BAD};
    applyStimulus(v);
`endif

    // Randomized instructions checked against the architectural model.
    for (int n = 0; n < 40; n++) begin
      v.rs = 5'($urandom);
      v.rt = 5'($urandom);
      v.rd = (n % 8 == 0) ? 5'd0 : 5'($urandom);
      v.funct = functs[$urandom_range(0, 4)];
      v.opDelay = $urandom_range(0, 3);
      v.resDelay = $urandom_range(0, 3);
      v.pulseWrong = 1'($urandom_range(0, 1));
      v.expA = modelRegs[v.rs];
      v.expB = modelRegs[v.rt];
      v.res = aluRef(v.funct, v.expA, v.expB);
      applyStimulus(v);
    end

    // Final architectural state of the register file.
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("reg_r%0d", i), regs[i], modelRegs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
